// File: rtl/dmd_count_fifo.sv
// dmd_count_fifo: capture FIFO for per-pattern photon counts.
// The running count is latched on each DMD pattern strobe rise and committed
// on its fall. The host pops samples oldest-first with an asynchronous read
// strobe. Both strobes are synchronised here; events act two edges after the
// first edge that samples the new level.
module dmd_count_fifo #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int OVERWRITE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              dmd_sig,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int CW = ADDR_W + 1;

    // Strobe synchronisers: bit 0 samples the pin, bits [2:1] are compared
    logic [2:0]        dmd_s_q, dmd_s_d;
    logic [2:0]        rd_s_q, rd_s_d;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;

    // Storage is not reset; entries are only readable once committed
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;

    logic dmd_rise, dmd_fall, rd_rise;
    logic is_full, is_empty;
    logic do_pop, do_drop, do_push;

    assign dmd_rise = (dmd_s_q[2:1] == 2'b01);
    assign dmd_fall = (dmd_s_q[2:1] == 2'b10);
    assign rd_rise  = (rd_s_q[2:1]  == 2'b01);
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // Next-state: read, capture and commit resolved against the pre-edge count
    always_comb begin
        dmd_s_d      = {dmd_s_q[1:0], dmd_sig};
        rd_s_d       = {rd_s_q[1:0], rd};
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        mem_we       = 1'b0;
        do_pop       = 1'b0;
        do_drop      = 1'b0;
        do_push      = 1'b0;

        if (clear) begin
            // Flush; any strobe event landing on this edge is discarded
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pending_d   = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (rd_rise) begin
                if (!is_empty) begin
                    data_out_d   = mem[rd_ptr_q];
                    data_valid_d = 1'b1;
                    do_pop       = 1'b1;
                end else begin
                    underflow_d = 1'b1;
                end
            end

            if (dmd_rise) begin
                if (!is_full) begin
                    mem_we    = 1'b1;
                    pending_d = 1'b1;
                end else if (OVERWRITE != 0) begin
                    // Free the oldest slot; a simultaneous read already did
                    mem_we     = 1'b1;
                    pending_d  = 1'b1;
                    overflow_d = 1'b1;
                    do_drop    = !do_pop;
                end else begin
                    overflow_d = 1'b1;
                end
            end

            if (dmd_fall && pending_q) begin
                do_push   = 1'b1;
                pending_d = 1'b0;
            end

            if (do_pop || do_drop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push)           wr_ptr_d = wr_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop || do_drop);
        end
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmd_s_q      <= '0;
            rd_s_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            dmd_s_q      <= dmd_s_d;
            rd_s_q       <= rd_s_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Sample storage write on capture
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= data_in;
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign count      = count_q;
    assign full       = is_full;
    assign empty      = is_empty;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_dmd_count_fifo.sv
// Bench for dmd_count_fifo: three instances (default depth, DEPTH=4 drop,
// DEPTH=4 overwrite) share one stimulus stream; a queue-based model of each
// is checked against its instance every cycle, plus literal spot checks.
module tb_dmd_count_fifo;

    logic        clk = 1'b0;
    logic        rst, clear, dmd_sig, rd;
    logic [15:0] data_in;

    logic [15:0] do0, do1, do2;
    logic        dv0, dv1, dv2;
    logic [10:0] cnt0;
    logic [2:0]  cnt1, cnt2;
    logic        fu0, fu1, fu2, em0, em1, em2;
    logic        ov0, ov1, ov2, un0, un1, un2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmd_count_fifo u0 (
        .clk(clk), .rst(rst), .clear(clear), .dmd_sig(dmd_sig), .rd(rd), .data_in(data_in),
        .data_out(do0), .data_valid(dv0), .count(cnt0), .full(fu0), .empty(em0),
        .overflow(ov0), .underflow(un0));

    dmd_count_fifo #(.DEPTH(4), .OVERWRITE(0)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .dmd_sig(dmd_sig), .rd(rd), .data_in(data_in),
        .data_out(do1), .data_valid(dv1), .count(cnt1), .full(fu1), .empty(em1),
        .overflow(ov1), .underflow(un1));

    dmd_count_fifo #(.DEPTH(4), .OVERWRITE(1)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .dmd_sig(dmd_sig), .rd(rd), .data_in(data_in),
        .data_out(do2), .data_valid(dv2), .count(cnt2), .full(fu2), .empty(em2),
        .overflow(ov2), .underflow(un2));

    // ---------------- behavioural model ----------------
    logic [15:0] q0[$], q1[$], q2[$];
    logic [15:0] m_do [3];
    logic        m_dv [3], m_pend [3], m_ovf [3], m_unf [3];
    logic [15:0] m_pv [3];
    // strobe levels seen at the last three edges: [0] newest
    logic [2:0]  hd, hr;

    function automatic int dep_of(input int m);
        return (m == 0) ? 1024 : 4;
    endfunction

    function automatic int qsize(input int m);
        case (m)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int m, input logic [15:0] v);
        case (m)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic qpop(input int m, output logic [15:0] v);
        case (m)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic qclear(input int m);
        case (m)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 3; m++) begin
                qclear(m);
                m_do[m] = '0; m_dv[m] = 0; m_pend[m] = 0; m_pv[m] = '0;
                m_ovf[m] = 0; m_unf[m] = 0;
            end
            hd = '0;
            hr = '0;
        end else begin
            // An event acts two edges after the new level is first sampled
            logic ev_cap, ev_com, ev_rd;
            ev_cap = !hd[2] && hd[1];
            ev_com = hd[2] && !hd[1];
            ev_rd  = !hr[2] && hr[1];
            for (int m = 0; m < 3; m++) begin
                int sz0;
                logic popped;
                logic [15:0] v;
                m_dv[m] = 0;
                sz0 = qsize(m);
                popped = 0;
                if (clear) begin
                    qclear(m);
                    m_pend[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
                end else begin
                    if (ev_rd) begin
                        if (sz0 > 0) begin
                            qpop(m, v);
                            m_do[m] = v; m_dv[m] = 1; popped = 1;
                        end else begin
                            m_unf[m] = 1;
                        end
                    end
                    if (ev_cap) begin
                        if (sz0 < dep_of(m)) begin
                            m_pend[m] = 1; m_pv[m] = data_in;
                        end else if (m == 2) begin
                            m_ovf[m] = 1;
                            if (!popped) qpop(m, v);
                            m_pend[m] = 1; m_pv[m] = data_in;
                        end else begin
                            m_ovf[m] = 1;
                        end
                    end
                    if (ev_com && m_pend[m]) begin
                        qpush(m, m_pv[m]);
                        m_pend[m] = 0;
                    end
                end
            end
            hd = {hd[1:0], dmd_sig};
            hr = {hr[1:0], rd};
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int m, input logic [15:0] d, input logic v, input int c,
                           input logic f, input logic e, input logic o, input logic u);
        int sz;
        sz = qsize(m);
        chk($sformatf("u%0d.data_out", m), int'(d), int'(m_do[m]));
        chk($sformatf("u%0d.data_valid", m), int'(v), int'(m_dv[m]));
        chk($sformatf("u%0d.count", m), c, sz);
        chk($sformatf("u%0d.full", m), int'(f), int'(sz == dep_of(m)));
        chk($sformatf("u%0d.empty", m), int'(e), int'(sz == 0));
        chk($sformatf("u%0d.overflow", m), int'(o), int'(m_ovf[m]));
        chk($sformatf("u%0d.underflow", m), int'(u), int'(m_unf[m]));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, do0, dv0, int'(cnt0), fu0, em0, ov0, un0);
        cmp_dut(1, do1, dv1, int'(cnt1), fu1, em1, ov1, un1);
        cmp_dut(2, do2, dv2, int'(cnt2), fu2, em2, ov2, un2);
    end

    // ---------------- stimulus ----------------
    task automatic pulse_dmd(input logic [15:0] v);
        @(negedge clk);
        data_in = v;
        dmd_sig = 1'b1;
        repeat (4) @(negedge clk);
        dmd_sig = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        rd = 1'b1;
        repeat (4) @(negedge clk);
        rd = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; dmd_sig = 1'b0; rd = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_count", int'(cnt0), 0);
        chk("reset_empty", int'(em0), 1);
        chk("reset_data_out", int'(do0), 0);

        // Three captures, three reads, with data_valid timing on the first
        pulse_dmd(16'd5);      chk("A_count1", int'(cnt0), 1);
        pulse_dmd(16'd9);      chk("A_count2", int'(cnt0), 2);
        pulse_dmd(16'hFFFF);   chk("A_count3", int'(cnt0), 3);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk); chk("A_dv_e0", int'(dv0), 0);
        @(negedge clk); chk("A_dv_e1", int'(dv0), 0);
        @(negedge clk); chk("A_dv_e2", int'(dv0), 1); chk("A_rd1", int'(do0), 5);
        @(negedge clk); chk("A_dv_e3", int'(dv0), 0);
        rd = 1'b0;
        repeat (4) @(negedge clk);
        chk("A_count4", int'(cnt0), 2);
        pulse_rd(); chk("A_rd2", int'(do0), 9);      chk("A_count5", int'(cnt0), 1);
        pulse_rd(); chk("A_rd3", int'(do0), 16'hFFFF); chk("A_count6", int'(cnt0), 0);

        // DEPTH=4 drop mode: five captures
        do_clear();
        for (int i = 1; i <= 5; i++) pulse_dmd(16'(i));
        chk("B_full", int'(fu1), 1);
        chk("B_count", int'(cnt1), 4);
        chk("B_ovf", int'(ov1), 1);
        for (int i = 1; i <= 4; i++) begin
            pulse_rd();
            chk($sformatf("B_rd%0d", i), int'(do1), i);
        end
        pulse_rd();
        chk("B_unf", int'(un1), 1);
        chk("B_hold", int'(do1), 4);

        // DEPTH=4 overwrite mode: six captures keep the newest four
        do_clear();
        for (int i = 1; i <= 6; i++) pulse_dmd(16'(i));
        chk("C_count", int'(cnt2), 4);
        chk("C_ovf", int'(ov2), 1);
        for (int i = 3; i <= 6; i++) begin
            pulse_rd();
            chk($sformatf("C_rd%0d", i), int'(do2), i);
        end

        // Commit and read landing on the same edge
        do_clear();
        pulse_dmd(16'd10);
        pulse_dmd(16'd20);
        @(negedge clk);
        data_in = 16'd30;
        dmd_sig = 1'b1;
        repeat (4) @(negedge clk);
        dmd_sig = 1'b0;
        rd = 1'b1;
        repeat (4) @(negedge clk);
        chk("D_count", int'(cnt0), 2);
        chk("D_pop", int'(do0), 10);
        rd = 1'b0;
        repeat (4) @(negedge clk);
        pulse_rd(); chk("D_rd2", int'(do0), 20);
        pulse_rd(); chk("D_rd3", int'(do0), 30);

        // Clear with a read event in the clear cycle
        do_clear();
        for (int i = 1; i <= 5; i++) pulse_dmd(16'(i));
        pulse_rd();
        chk("E_pre_count", int'(cnt1), 3);
        chk("E_pre_ovf", int'(ov1), 1);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        rd = 1'b0;
        repeat (4) @(negedge clk);
        chk("E_count", int'(cnt1), 0);
        chk("E_empty", int'(em1), 1);
        chk("E_ovf", int'(ov1), 0);
        chk("E_unf", int'(un1), 0);
        chk("E_hold", int'(do1), 1);
        pulse_dmd(16'd42);
        pulse_rd();
        chk("E_rd42", int'(do1), 42);

        // Randomised strobes, clears and one mid-run reset
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) dmd_sig = ~dmd_sig;
            if ($urandom_range(0, 4) == 0) rd = ~rd;
            if ($urandom_range(0, 2) == 0) data_in = 16'($urandom);
            if (i == 2000) begin
                #2 rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end
        clear = 1'b0;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
